// File: rtl/dbit_counter.sv
// dbit_counter: counts the 1s of a unary bitstream over a 2^INWD-cycle window.
// Optional DBITCNT_SAT_EN narrows oCnt to INWD bits and saturates 2^INWD to 2^INWD-1.
`default_nettype none

module dbit_counter #(
  parameter int INWD = 8,
`ifdef DBITCNT_SAT_EN
  localparam int OUTWD = INWD
`else
  localparam int OUTWD = INWD + 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iBit,
  input  logic             start,
  output logic [OUTWD-1:0] oCnt,
  output logic             oValid,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INWD-1:0]    win_q, win_d;
  logic [INWD:0]      acc_q, acc_d;
  logic [OUTWD-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [INWD:0]      total_w;
  logic [OUTWD-1:0]   result_w;

  // Running total including the current sample; this is what lands in oCnt
  // on the last sample cycle.
  assign total_w = acc_q + {{INWD{1'b0}}, iBit};

`ifdef DBITCNT_SAT_EN
  assign result_w = total_w[INWD] ? {OUTWD{1'b1}} : total_w[INWD-1:0];
`else
  assign result_w = total_w;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          win_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = total_w;
        win_d = win_q + {{(INWD-1){1'b0}}, 1'b1};
        if (win_q == {INWD{1'b1}}) begin
          // Last sample: publish, and start a fresh window with no gap if requested.
          cnt_d   = result_w;
          valid_d = 1'b1;
          acc_d   = '0;
          win_d   = '0;
          state_d = start ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign oCnt   = cnt_q;
  assign oValid = valid_q;
  assign busy   = (state_q == ACCUM);

endmodule

`default_nettype wire
